// File: rtl/lsu_sw_in_if.sv
// LSU data-bus port of the switch/key input window: load and store requests
// plus the registered load response.
interface lsu_sw_in_if;
   logic        ld_en;
   logic        st_en;
   logic [2:0]  datamode;
   logic        ld_unsigned;
   logic [3:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_o;
   logic        ld_valid;

   modport master (
      output ld_en, st_en, datamode, ld_unsigned, addr, data_in,
      input  data_o, ld_valid
   );

   modport slave (
      input  ld_en, st_en, datamode, ld_unsigned, addr, data_in,
      output data_o, ld_valid
   );
endinterface

// File: rtl/lsu_sw_in.sv
// Switch/push-button input peripheral: synchronizes and debounces the board
// inputs, counts key presses and serves loads from a 16-byte register window.
module lsu_sw_in #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [17:0] sw_i,
   input  logic [3:0]  key_i,
   lsu_sw_in_if.slave  bus
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // Compared before the increment, so the flip lands DEBOUNCE_CYCLES+1 edges
   // after the synchronized key first differs.
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [3:0]       FLAG_ADDR = 4'h5;

   function automatic logic [31:0] ext_load(input logic [31:0] raw,
                                            input logic [2:0]  mode,
                                            input logic        uns);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = raw[7:0];
      h = raw[15:0];
      case (mode)
         3'd0:    ext_load = uns ? {24'h0, raw[7:0]}  : {{24{b[7]}}, b};
         3'd1:    ext_load = uns ? {16'h0, raw[15:0]} : {{16{h[15]}}, h};
         default: ext_load = raw;
      endcase
   endfunction

   function automatic logic [2:0] lane_count(input logic [2:0] mode);
      case (mode)
         3'd0:    lane_count = 3'd1;
         3'd1:    lane_count = 3'd2;
         default: lane_count = 3'd4;
      endcase
   endfunction

   function automatic logic [2:0] rise_count(input logic [3:0] r);
      rise_count = 3'(r[0]) + 3'(r[1]) + 3'(r[2]) + 3'(r[3]);
   endfunction

   logic [17:0]      sw_p0, sw_p1;
   logic [3:0]       key_p0, key_p1;
   logic [3:0]       key_stable_p2, key_stable_nxt;
   logic [CNT_W-1:0] db_cnt_p2  [4];
   logic [CNT_W-1:0] db_cnt_nxt [4];
   logic [3:0]       rise;
   logic [3:0]       press_flag, press_flag_nxt;
   logic [31:0]      press_count, press_count_nxt;
   logic [2:0]       n_lanes;
   logic [7:0]       st_byte;
   logic [3:0]       st_clr;
   logic             unused_st_hi;
   logic [7:0]       win [16];
   logic [31:0]      ld_raw;

   // Stage p0/p1: two-flop synchronizers; keys inverted so 1 = pressed
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sw_p0  <= '0;
         sw_p1  <= '0;
         key_p0 <= '0;
         key_p1 <= '0;
      end else begin
         sw_p0  <= sw_i;
         sw_p1  <= sw_p0;
         key_p0 <= ~key_i;
         key_p1 <= key_p0;
      end
   end

   // Stage p2: per-key debounce counters and stable key state
   always_comb begin
      key_stable_nxt = key_stable_p2;
      for (int k = 0; k < 4; k++) begin
         db_cnt_nxt[k] = '0;
         if (key_p1[k] != key_stable_p2[k]) begin
            if (db_cnt_p2[k] == CNT_LAST) begin
               key_stable_nxt[k] = ~key_stable_p2[k];
            end else begin
               db_cnt_nxt[k] = db_cnt_p2[k] + CNT_W'(1);
            end
         end
      end
   end

   assign rise    = key_stable_nxt & ~key_stable_p2;
   assign n_lanes = lane_count(bus.datamode);

   always_comb begin
      st_byte = '0;
      for (int i = 0; i < 4; i++) begin
         if ((3'(i) < n_lanes) && ((bus.addr + 4'(i)) == FLAG_ADDR)) begin
            st_byte = bus.data_in[8*i +: 8];
         end
      end
      st_clr = bus.st_en ? st_byte[3:0] : 4'h0;
   end

   assign unused_st_hi = ^st_byte[7:4];

   // A press arriving on the same edge as a clear keeps its flag set.
   assign press_flag_nxt  = (press_flag & ~st_clr) | rise;
   assign press_count_nxt = press_count + 32'(rise_count(rise));

   always_comb begin
      for (int j = 0; j < 16; j++) begin
         win[j] = '0;
      end
      win[0]  = sw_p1[7:0];
      win[1]  = sw_p1[15:8];
      win[2]  = {6'h0, sw_p1[17:16]};
      win[4]  = {4'h0, key_stable_p2};
      win[5]  = {4'h0, press_flag};
      win[8]  = press_count[7:0];
      win[9]  = press_count[15:8];
      win[10] = press_count[23:16];
      win[11] = press_count[31:24];
      ld_raw  = '0;
      for (int i = 0; i < 4; i++) begin
         ld_raw[8*i +: 8] = win[bus.addr + 4'(i)];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         key_stable_p2 <= '0;
         for (int k = 0; k < 4; k++) begin
            db_cnt_p2[k] <= '0;
         end
         press_flag  <= '0;
         press_count <= '0;
      end else begin
         key_stable_p2 <= key_stable_nxt;
         for (int k = 0; k < 4; k++) begin
            db_cnt_p2[k] <= db_cnt_nxt[k];
         end
         press_flag  <= press_flag_nxt;
         press_count <= press_count_nxt;
      end
   end

   // Load response register: reads the window as it stood before this edge
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.data_o   <= '0;
         bus.ld_valid <= 1'b0;
      end else begin
         bus.ld_valid <= bus.ld_en;
         if (bus.ld_en) begin
            bus.data_o <= ext_load(ld_raw, bus.datamode, bus.ld_unsigned);
         end
      end
   end

endmodule

// File: tb/tb_lsu_sw_in.sv
// Directed-vector bench for lsu_sw_in with a queue-based scoreboard.
module tb_lsu_sw_in;
   localparam int DB = 16;

   logic        clk   = 1'b0;
   logic        rst_i = 1'b1;
   logic [17:0] sw_i  = '0;
   logic [3:0]  key_i = 4'hF;

   lsu_sw_in_if bus();

   lsu_sw_in #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .sw_i  (sw_i),
      .key_i (key_i),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q  [$];
   string       name_q [$];
   logic [31:0] last_exp = '0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input string nm, input logic [3:0] a, input logic [2:0] m,
                       input logic u, input logic [31:0] e);
      bus.ld_en       = 1'b1;
      bus.addr        = a;
      bus.datamode    = m;
      bus.ld_unsigned = u;
      exp_q.push_back(e);
      name_q.push_back(nm);
      tick();
      bus.ld_en = 1'b0;
   endtask

   task automatic store(input logic [3:0] a, input logic [2:0] m, input logic [31:0] d);
      bus.st_en    = 1'b1;
      bus.addr     = a;
      bus.datamode = m;
      bus.data_in  = d;
      tick();
      bus.st_en = 1'b0;
   endtask

   task automatic ldst(input string nm, input logic [3:0] a, input logic [2:0] m,
                       input logic [31:0] d, input logic [31:0] e);
      bus.st_en       = 1'b1;
      bus.data_in     = d;
      bus.ld_unsigned = 1'b1;
      bus.ld_en       = 1'b1;
      bus.addr        = a;
      bus.datamode    = m;
      exp_q.push_back(e);
      name_q.push_back(nm);
      tick();
      bus.ld_en = 1'b0;
      bus.st_en = 1'b0;
   endtask

   // Monitor: pops one expectation per presented load, otherwise checks hold.
   always @(negedge clk) begin
      if (rst_i) begin
         last_exp = '0;
      end else if (bus.ld_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_load: got %h want no load", bus.data_o);
         end else begin
            string       nm;
            logic [31:0] e;
            nm = name_q.pop_front();
            e  = exp_q.pop_front();
            check(nm, bus.data_o, e);
            last_exp = e;
         end
      end else begin
         check("data_hold", bus.data_o, last_exp);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ld_en       = 1'b0;
      bus.st_en       = 1'b0;
      bus.datamode    = 3'd0;
      bus.ld_unsigned = 1'b0;
      bus.addr        = 4'h0;
      bus.data_in     = '0;
      repeat (3) tick();
      check("rst_ld_valid", 32'(bus.ld_valid), 32'h0);
      check("rst_data_o", bus.data_o, 32'h0);
      rst_i = 1'b0;

      // switch word and ld_valid fall
      sw_i = 18'h2A5A5;
      tick();
      tick();
      load("sw_word", 4'h0, 3'd2, 1'b0, 32'h0002A5A5);
      tick();
      check("ld_valid_fall", 32'(bus.ld_valid), 32'h0);
      check("data_after_fall", bus.data_o, 32'h0002A5A5);

      // short glitch on key 0
      key_i = 4'hE;
      repeat (10) tick();
      key_i = 4'hF;
      repeat (25) tick();
      load("glitch_stable", 4'h4, 3'd0, 1'b1, 32'h0);
      load("glitch_flag", 4'h5, 3'd0, 1'b1, 32'h0);
      load("glitch_count", 4'h8, 3'd2, 1'b0, 32'h0);

      // key 2 held: stable flips 19 edges after the raw change
      key_i = 4'hB;
      repeat (18) tick();
      load("k2_edge19_pre", 4'h4, 3'd0, 1'b1, 32'h0);
      load("k2_edge20_post", 4'h4, 3'd0, 1'b1, 32'h4);
      load("k2_flag", 4'h5, 3'd0, 1'b1, 32'h4);
      load("k2_count", 4'h8, 3'd2, 1'b0, 32'h1);
      key_i = 4'hF;
      repeat (25) tick();
      load("k2_release", 4'h4, 3'd0, 1'b1, 32'h0);
      load("k2_release_cnt", 4'h8, 3'd2, 1'b0, 32'h1);

      // three keys rise on one edge
      key_i = 4'h4;
      repeat (25) tick();
      load("multi_flag", 4'h5, 3'd0, 1'b1, 32'hF);
      load("multi_count", 4'h8, 3'd2, 1'b0, 32'h4);
      load("half_keys", 4'h4, 3'd1, 1'b1, 32'h00000F0B);
      key_i = 4'hF;
      repeat (25) tick();

      // write-1-to-clear of press flags
      store(4'h5, 3'd0, 32'h00000005);
      load("clr_05", 4'h5, 3'd0, 1'b1, 32'hA);
      store(4'h0, 3'd2, 32'hFFFFFFFF);
      load("st_other", 4'h5, 3'd0, 1'b1, 32'hA);
      store(4'h2, 3'd2, 32'h02000000);
      load("st_word_lane3", 4'h5, 3'd0, 1'b1, 32'h8);
      store(4'h4, 3'd1, 32'h0000F000);
      load("st_hi_ignored", 4'h5, 3'd0, 1'b1, 32'h8);

      // clear coinciding with key 0 press; load in same cycle sees old flags
      key_i = 4'hE;
      repeat (18) tick();
      ldst("ldst_pre", 4'h5, 3'd0, 32'h00000005, 32'h8);
      load("set_wins", 4'h5, 3'd0, 1'b1, 32'h9);
      load("count5", 4'h8, 3'd2, 1'b0, 32'h5);
      key_i = 4'hF;
      repeat (25) tick();

      // sign extension and address wrap
      sw_i = 18'h00080;
      tick();
      tick();
      load("byte_signed", 4'h0, 3'd0, 1'b0, 32'hFFFFFF80);
      load("byte_unsigned", 4'h0, 3'd0, 1'b1, 32'h00000080);
      load("half_wrap_s", 4'hF, 3'd1, 1'b0, 32'hFFFF8000);
      load("half_wrap_u", 4'hF, 3'd1, 1'b1, 32'h00008000);
      load("word_wrap_e", 4'hE, 3'd2, 1'b0, 32'h00800000);
      load("word_wrap_d", 4'hD, 3'd7, 1'b1, 32'h80000000);
      load("half_zero_b", 4'hB, 3'd1, 1'b0, 32'h0);

      // reset mid-debounce with key 3 held
      key_i = 4'h7;
      repeat (8) tick();
      rst_i = 1'b1;
      tick();
      tick();
      check("rst2_ld_valid", 32'(bus.ld_valid), 32'h0);
      check("rst2_data_o", bus.data_o, 32'h0);
      rst_i = 1'b0;
      load("rst2_count", 4'h8, 3'd2, 1'b0, 32'h0);
      load("rst2_stable", 4'h4, 3'd0, 1'b1, 32'h0);
      load("rst2_flag", 4'h5, 3'd0, 1'b1, 32'h0);
      repeat (15) tick();
      load("rst2_edge19_pre", 4'h8, 3'd2, 1'b0, 32'h0);
      load("rst2_edge20_post", 4'h8, 3'd2, 1'b0, 32'h1);
      load("rst2_flag_post", 4'h5, 3'd0, 1'b1, 32'h8);
      tick();
      tick();
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
